alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction issue controller for the 3-stage `pipelined_alu` datapath. It buffers instructions from a single requester in a small FIFO and drives the ALU's `rs1/rs2/rd/func/addr` inputs every cycle. The ALU has no forwarding, so the controller detects read-after-write hazards and inserts bubbles when needed. It reports each instruction's completion when its result appears on the ALU's `z` output.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — instruction buffer entries; power of two, ≥2
- `BUBBLE_FUNC`, 4'b1111 — func code for a bubble; ALU default case, result 0
- `BUBBLE_RD`, 4'd15 — reserved scratch register written by bubbles
- `BUBBLE_ADDR`, 8'hFF — reserved memory word written by bubbles

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in 1 — requester presents an instruction
- `req_ready` out 1 — FIFO can accept an instruction
- `req_rs1`, `req_rs2`, `req_rd` in 4 each — register indices
- `req_func` in 4 — ALU opcode
- `req_addr` in 8 — memory write address
- `alu_rs1`, `alu_rs2`, `alu_rd`, `alu_func` out 4 each — registered drive to the ALU
- `alu_addr` out 8 — registered drive to the ALU
- `cmp_valid` out 1 — a real instruction's result is on ALU `z` this cycle
- `cmp_rd` out 4 — destination register of the completing instruction
- `busy` out 1 — FIFO non-empty or any instruction in flight
- `stall_cnt` out 16 — saturating count of hazard bubbles

## Operation
- Handshake: a push occurs on a cycle where `req_valid && req_ready`. `req_ready = !full`, from registered occupancy. There is no combinational path from `req_valid` to `req_ready`.
- Software must not use r15 or address 8'hFF for real instructions; the controller does not check this.
- Drive cycle: every cycle the controller registers one slot onto the `alu_*` outputs, either the FIFO head (issue) or a bubble (`BUBBLE_FUNC`, `BUBBLE_RD`, `BUBBLE_ADDR`, rs1 = rs2 = 0).
- A slot driven in cycle c is captured by the ALU at edge c+1. It writes the register bank at edge c+3, and its `z` is valid during cycle c+3.
- Hazard window:
  - H1 holds the rd of the slot driven last cycle, with a valid bit.
  - H2 holds the rd of the slot driven two cycles ago, with a valid bit.
  - Bubbles set the valid bit to 0.
  - The head is blocked if a valid H1 or H2 rd equals the head's rs1 or rs2. A dependent therefore issues no earlier than 3 cycles after its producer.
- Issue rule: if the FIFO is non-empty and the head is not blocked, pop the head and drive it. Otherwise drive a bubble.
- `stall_cnt` increments only on a bubble driven while the FIFO is non-empty and blocked. It saturates at 16'hFFFF.
- WAW and WAR hazards need no check: the pipeline is in-order.
- Completion: a 3-deep valid/rd shift register follows each driven slot. `cmp_valid`/`cmp_rd` equal its tail, so `cmp_valid` asserts in cycle c+3 for a real instruction driven in cycle c.
- Simultaneous push and pop are allowed when the FIFO is not full; occupancy is unchanged.
- A pushed entry can issue at the earliest in the cycle after the push.

## Timing
- Reset values:
  - `alu_*` = bubble encoding
  - `req_ready` = 1
  - `cmp_valid` = 0, `cmp_rd` = 0
  - `busy` = 0
  - `stall_cnt` = 0
  - FIFO empty; H1, H2 and the completion shift register all invalid
- Reset mid-operation: FIFO contents are discarded. The ALU has no reset, so in-flight instructions still write the register bank, but their `cmp_valid` is suppressed.
- Independent stream: one issue per cycle, throughput 1/cycle.
- Back-to-back dependent pair: the dependent is driven 3 cycles after its producer, with 2 bubbles between them.
- Full FIFO: `req_ready` = 0 on the cycle after the push that fills it. It returns to 1 the cycle after the next pop.

## Structure
- Package `alu_ctrl_pkg` holds:
  - func code constants: ADD = 0, SUB = 1, MUL = 2, PASSA = 3, PASSB = 4, NOTA = 5, NOTB = 6, SHLA = 7, SHRA = 9, SHLB = 10
  - the bubble constants
  - `instr_t` packed typedef {rs1, rs2, rd, func, addr}, 24 bits
- Sub-module `alu_instr_fifo`: synchronous FIFO of `instr_t` with full/empty/count outputs. Hazard logic, issue mux and completion tracking live in `alu_issue_ctrl`.

## Test plan
- Independent stream: push ADD r1←r2,r3; SUB r4←r5,r6; MUL r7←r8,r9 on consecutive cycles.
  - Required: driven in 3 consecutive cycles with no bubbles; `cmp_valid` high for 3 cycles with `cmp_rd` = 1, 4, 7; `stall_cnt` = 0.
- RAW distance 1: push ADD r1←r2,r3, then SUB r4←r1,r5.
  - Required: SUB driven exactly 3 cycles after ADD, 2 bubbles between, `stall_cnt` = 2.
  - With the ALU attached, r2 = 5 and r3 = 7 preloaded: ADD gives r1 = 12, and SUB with r5 = 2 gives z = 16'd10.
- RAW on rs2 at distance 2: push ADD r1←r2,r3; PASSA r6←r7; NOTB r8←r0,r1.
  - Required: exactly 1 bubble before NOTB, `stall_cnt` = 1.
- Full FIFO: hold a blocked head and push FIFO_DEPTH+1 instructions.
  - Required: `req_ready` drops after the 4th accepted push; the 5th is accepted only after a pop; no entry is lost or duplicated.
- Reset mid-flight: assert `rst` for 1 cycle with 2 queued and 2 in-flight instructions.
  - Required: next cycle all outputs are at reset values, `cmp_valid` stays 0 for the following 3 cycles, `busy` = 0.
- Saturation: force `stall_cnt` to 16'hFFFE and create 3 hazard bubbles.
  - Required: `stall_cnt` reads 16'hFFFF and holds there.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared func codes, bubble encoding and instruction type for the ALU issue controller
package alu_ctrl_pkg;

  localparam logic [3:0] FUNC_ADD   = 4'd0;
  localparam logic [3:0] FUNC_SUB   = 4'd1;
  localparam logic [3:0] FUNC_MUL   = 4'd2;
  localparam logic [3:0] FUNC_PASSA = 4'd3;
  localparam logic [3:0] FUNC_PASSB = 4'd4;
  localparam logic [3:0] FUNC_NOTA  = 4'd5;
  localparam logic [3:0] FUNC_NOTB  = 4'd6;
  localparam logic [3:0] FUNC_SHLA  = 4'd7;
  localparam logic [3:0] FUNC_SHRA  = 4'd9;
  localparam logic [3:0] FUNC_SHLB  = 4'd10;

  // Bubbles hit the ALU default case and write 0 to a reserved register/address
  localparam logic [3:0] DEF_BUBBLE_FUNC = 4'b1111;
  localparam logic [3:0] DEF_BUBBLE_RD   = 4'd15;
  localparam logic [7:0] DEF_BUBBLE_ADDR = 8'hFF;

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } instr_t;

endpackage

// File: rtl/alu_instr_fifo.sv
// rtl/alu_instr_fifo.sv - synchronous instruction FIFO with first-word-fall-through head
module alu_instr_fifo
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  instr_t                   wdata,
  input  logic                     pop,
  output instr_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  instr_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues buffered instructions to the 3-stage ALU with RAW bubbles and completion tracking
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] BUBBLE_FUNC = DEF_BUBBLE_FUNC,
  parameter logic [3:0] BUBBLE_RD   = DEF_BUBBLE_RD,
  parameter logic [7:0] BUBBLE_ADDR = DEF_BUBBLE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_rs1,
  input  logic [3:0]  req_rs2,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_func,
  input  logic [7:0]  req_addr,
  output logic [3:0]  alu_rs1,
  output logic [3:0]  alu_rs2,
  output logic [3:0]  alu_rd,
  output logic [3:0]  alu_func,
  output logic [7:0]  alu_addr,
  output logic        cmp_valid,
  output logic [3:0]  cmp_rd,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  instr_t          req_instr;
  instr_t          head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            issue;
  logic            h1_hit;
  logic            h2_hit;

  // H1 is the slot currently on alu_*; s1..s3 trail it, so s1 doubles as H2
  logic            h1_valid;
  logic            s1_valid, s2_valid, s3_valid;
  logic [3:0]      s1_rd, s2_rd, s3_rd;
  logic [15:0]     stall_q;

  assign req_instr = '{rs1: req_rs1, rs2: req_rs2, rd: req_rd, func: req_func, addr: req_addr};
  assign req_ready = !full;

  alu_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .wdata (req_instr),
    .pop   (issue),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign h1_hit = h1_valid && ((alu_rd == head.rs1) || (alu_rd == head.rs2));
  assign h2_hit = s1_valid && ((s1_rd == head.rs1) || (s1_rd == head.rs2));
  assign issue  = !empty && !h1_hit && !h2_hit;

  assign cmp_valid = s3_valid;
  assign cmp_rd    = s3_rd;
  assign busy      = (count != '0) || h1_valid || s1_valid || s2_valid || s3_valid;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_rs1  <= '0;
      alu_rs2  <= '0;
      alu_rd   <= BUBBLE_RD;
      alu_func <= BUBBLE_FUNC;
      alu_addr <= BUBBLE_ADDR;
      h1_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_rd    <= '0;
      s2_rd    <= '0;
      s3_rd    <= '0;
      stall_q  <= '0;
    end else begin
      if (issue) begin
        alu_rs1  <= head.rs1;
        alu_rs2  <= head.rs2;
        alu_rd   <= head.rd;
        alu_func <= head.func;
        alu_addr <= head.addr;
      end else begin
        alu_rs1  <= '0;
        alu_rs2  <= '0;
        alu_rd   <= BUBBLE_RD;
        alu_func <= BUBBLE_FUNC;
        alu_addr <= BUBBLE_ADDR;
      end
      h1_valid <= issue;
      s1_valid <= h1_valid;
      s1_rd    <= alu_rd;
      s2_valid <= s1_valid;
      s2_rd    <= s1_rd;
      s3_valid <= s2_valid;
      s3_rd    <= s2_rd;
      // Only hazard bubbles count; idle bubbles with an empty FIFO do not
      if (!empty && !issue && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with directed hazard, full, reset and saturation vectors
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_rs1, req_rs2, req_rd, req_func;
  logic [7:0]  req_addr;
  logic [3:0]  alu_rs1, alu_rs2, alu_rd, alu_func;
  logic [7:0]  alu_addr;
  logic        cmp_valid;
  logic [3:0]  cmp_rd;
  logic        busy;
  logic [15:0] stall_cnt;

  typedef struct {
    int rd;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   p;

  alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_rd    (req_rd),
    .req_func  (req_func),
    .req_addr  (req_addr),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_rd    (alu_rd),
    .alu_func  (alu_func),
    .alu_addr  (alu_addr),
    .cmp_valid (cmp_valid),
    .cmp_rd    (cmp_rd),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic expect_cmp(input int rd, input int at);
    exp_t e;
    e.rd  = rd;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd, input logic [3:0] func);
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    req_func  = func;
    req_addr  = {4'h0, rd};
  endtask

  task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd, input logic [3:0] func);
    set_req(rs1, rs2, rd, func);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Completion monitor: every cmp_valid must match the oldest expected completion, rd and cycle
  always @(negedge clk) begin
    if (cmp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmp_rd", int'(cmp_rd), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cmp_rd", int'(cmp_rd), e.rd);
        check("cmp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_func = '0; req_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_alu_func", int'(alu_func), 15);
    check("rst_alu_rd", int'(alu_rd), 15);
    check("rst_alu_addr", int'(alu_addr), 255);
    check("rst_alu_rs", int'({alu_rs1, alu_rs2}), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_cmp", int'({cmp_valid, cmp_rd}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_stall", int'(stall_cnt), 0);
    @(posedge clk); #1;

    // Independent stream: back-to-back completions, no bubbles
    p = cyc;
    expect_cmp(1, p + 5); expect_cmp(4, p + 6); expect_cmp(7, p + 7);
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd5, 4'd6, 4'd4, FUNC_SUB);
    drive(4'd8, 4'd9, 4'd7, FUNC_MUL);
    idle(8);
    @(negedge clk);
    check("indep_stall", int'(stall_cnt), 0);
    check("indep_busy", int'(busy), 0);
    @(posedge clk); #1;

    // RAW distance 1 on rs1: dependent three cycles after producer
    p = cyc;
    expect_cmp(1, p + 5); expect_cmp(4, p + 8);
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd1, 4'd5, 4'd4, FUNC_SUB);
    idle(10);
    @(negedge clk);
    check("raw1_stall", int'(stall_cnt), 2);
    @(posedge clk); #1;

    // RAW distance 2 on rs2: a single bubble
    p = cyc;
    expect_cmp(1, p + 5); expect_cmp(6, p + 6); expect_cmp(8, p + 8);
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd7, 4'd0, 4'd6, FUNC_PASSA);
    drive(4'd0, 4'd1, 4'd8, FUNC_NOTB);
    idle(10);
    @(negedge clk);
    check("raw2_stall", int'(stall_cnt), 3);
    @(posedge clk); #1;

    // Full FIFO: a dependency chain drains one entry per three cycles
    p = cyc;
    expect_cmp(1, p + 5);  expect_cmp(4, p + 8);  expect_cmp(5, p + 11);
    expect_cmp(6, p + 14); expect_cmp(7, p + 17); expect_cmp(8, p + 20);
    expect_cmp(9, p + 23);
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd1, 4'd5, 4'd4, FUNC_SUB);
    drive(4'd4, 4'd6, 4'd5, FUNC_MUL);
    drive(4'd5, 4'd7, 4'd6, FUNC_ADD);
    drive(4'd6, 4'd8, 4'd7, FUNC_SUB);
    drive(4'd7, 4'd9, 4'd8, FUNC_MUL);
    set_req(4'd8, 4'd2, 4'd9, FUNC_ADD);
    @(negedge clk);
    check("full_ready_low_a", int'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_ready_low_b", int'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_ready_back", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    idle(20);
    @(negedge clk);
    check("full_stall", int'(stall_cnt), 15);
    check("full_busy", int'(busy), 0);
    @(posedge clk); #1;

    // Reset with two queued and two in flight: their completions must vanish
    p = cyc;
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd2, 4'd3, 4'd4, FUNC_SUB);
    drive(4'd1, 4'd5, 4'd5, FUNC_MUL);
    drive(4'd6, 4'd7, 4'd6, FUNC_ADD);
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_alu_func", int'(alu_func), 15);
    check("mid_rst_alu_rd", int'(alu_rd), 15);
    check("mid_rst_alu_addr", int'(alu_addr), 255);
    check("mid_rst_ready", int'(req_ready), 1);
    check("mid_rst_cmp", int'({cmp_valid, cmp_rd}), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_stall", int'(stall_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_cmp_valid", int'(cmp_valid), 0);
      check("post_rst_busy", int'(busy), 0);
    end
    @(posedge clk); #1;

    // Saturation: preload near the top, then four hazard bubbles
    @(negedge clk);
    force dut.stall_q = 16'hFFFE;
    #1 release dut.stall_q;
    @(posedge clk); #1;
    p = cyc;
    expect_cmp(1, p + 5); expect_cmp(4, p + 8); expect_cmp(7, p + 11);
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd1, 4'd5, 4'd4, FUNC_SUB);
    drive(4'd4, 4'd8, 4'd7, FUNC_MUL);
    idle(12);
    @(negedge clk);
    check("sat_stall", int'(stall_cnt), 16'hFFFF);
    @(posedge clk); #1;
    drive(4'd2, 4'd3, 4'd1, FUNC_ADD);
    drive(4'd1, 4'd1, 4'd2, FUNC_ADD);
    expect_cmp(1, cyc + 3); expect_cmp(2, cyc + 6);
    idle(10);
    @(negedge clk);
    check("sat_hold", int'(stall_cnt), 16'hFFFF);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
